multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port OP, input, 6, opcode from instruction register (stable from S_ID onward).
REQ-004 SHALL have port func, input, 6, R-type function field.
REQ-005 SHALL have ports Zero and Overflow, inputs, 1 each, ALU flags.
REQ-006 SHALL have port MemReady, input, 1, data-memory completion handshake.
REQ-007 SHALL have outputs PCWr, IRWr, RegWr, MemRd, MemWr, ALUsrc, RegDst, MemtoReg, ExtOp, InstrDone, Illegal, 1 bit each.
REQ-008 SHALL have outputs ALUctr (3 bits), PCsrc (2 bits: 00 PC+4, 01 branch target, 10 jump target), state (3 bits, current state code).

Function
REQ-009 SHALL implement a Moore FSM: S_IF=0, S_ID=1, S_EX=2, S_WB=3, S_MA=4, S_MEM=5, S_LW=6, S_BR=7; outputs decoded from state plus OP/func/Zero/Overflow/MemReady only.
REQ-010 SHALL use ALUctr codes: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-011 SHALL decode: R-type OP=000000 with func 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; addi 001000; ori 001101; lw 100011; sw 101011; beq 000100; j 000010; anything else illegal.
REQ-012 S_IF: PCWr=1, PCsrc=00, IRWr=1; next S_ID.
REQ-013 S_ID: j -> PCWr=1, PCsrc=10, InstrDone=1, next S_IF; beq -> S_BR; R-type/addi/ori -> S_EX; lw/sw -> S_MA; illegal -> Illegal=1, InstrDone=1, next S_IF, no other strobe.
REQ-014 S_EX: R-type ALUsrc=0, ALUctr per func; addi ALUsrc=1, ExtOp=1, ALUctr=000; ori ALUsrc=1, ExtOp=0, ALUctr=011; next S_WB.
REQ-015 S_WB: ALUsrc/ExtOp/ALUctr held identical to S_EX; RegDst=1 for R-type else 0; MemtoReg=0; RegWr=1 except RegWr=0 when Overflow=1 for add, sub, addi; InstrDone=1; next S_IF.
REQ-016 S_MA: ALUsrc=1, ExtOp=1, ALUctr=000; next S_MEM.
REQ-017 S_MEM: S_MA ALU controls held; lw MemRd=1, sw MemWr=1, held every cycle while MemReady=0 (stay in S_MEM); on MemReady=1: sw -> InstrDone=1, next S_IF; lw -> next S_LW.
REQ-018 S_LW: RegWr=1, RegDst=0, MemtoReg=1, S_MA ALU controls held, InstrDone=1; next S_IF.
REQ-019 S_BR: ALUsrc=0, ALUctr=001; PCWr=Zero, PCsrc=01; InstrDone=1; next S_IF.
REQ-020 SHALL default every 1-bit output to 0, ALUctr to 000, PCsrc to 00 unless set above.
REQ-021 Latency (cycles, MemReady high on first S_MEM cycle): j 2, beq 3, R/addi/ori 4, sw 4, lw 5; each MemReady-low cycle adds 1.
REQ-022 PCWr and IRWr SHALL each be asserted at most once per instruction, except PCWr in S_IF plus one redirect (j/beq-taken).

Reset
REQ-023 While Reset=1, all strobes (PCWr, IRWr, RegWr, MemRd, MemWr, InstrDone, Illegal) SHALL be 0 combinationally.
REQ-024 On a rising CLK with Reset=1, state SHALL become S_IF (000) regardless of current state, including mid-S_MEM wait; a pending memory access is abandoned.
REQ-025 First cycle after Reset deasserts SHALL be S_IF with PCWr=1, IRWr=1.

Verification
REQ-026 add (OP=0, func=100000), Overflow=0 -> states 0,1,2,3; RegWr=1, RegDst=1 in state 3 only; InstrDone once.
REQ-027 lw, MemReady low 3 cycles then high -> states 0,1,4,5,5,5,5,6; MemRd=1 all four S_MEM cycles; RegWr=1, MemtoReg=1 in S_LW; 8 cycles total.
REQ-028 beq with Zero=1 then Zero=0 -> PCWr=1, PCsrc=01 in S_BR for first; PCWr=0 for second; both 3 cycles.
REQ-029 addi with Overflow=1 in S_WB -> RegWr=0, InstrDone=1, next state S_IF.
REQ-030 OP=111111 -> Illegal=1 in S_ID, no RegWr/MemWr/PCWr that cycle, return to S_IF; j -> PCsrc=10 in S_ID, 2 cycles.
REQ-031 Reset asserted during sw S_MEM wait -> MemWr=0 that cycle, state=000 next edge, no InstrDone.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit.
// Moore FSM: IF/ID/EX/WB/MA/MEM/LW/BR with memory handshake.
module multicycle_ctrl (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] OP,
  input  logic [5:0] func,
  input  logic       Zero,
  input  logic       Overflow,
  input  logic       MemReady,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       MemRd,
  output logic       MemWr,
  output logic       ALUsrc,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ExtOp,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [2:0] ALUctr,
  output logic [1:0] PCsrc,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_WB  = 3'd3,
    S_MA  = 3'd4,
    S_MEM = 3'd5,
    S_LW  = 3'd6,
    S_BR  = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_t r_state;
  state_t w_next;

  logic       w_f_add;
  logic       w_f_sub;
  logic       w_f_and;
  logic       w_f_or;
  logic       w_f_slt;
  logic       w_rtype;
  logic       w_addi;
  logic       w_ori;
  logic       w_lw;
  logic       w_sw;
  logic       w_beq;
  logic       w_j;
  logic       w_ovf_chk;
  logic       w_ex_alusrc;
  logic       w_ex_extop;
  logic [2:0] w_ex_aluctr;

  // Instruction decode from opcode and function field.
  always_comb begin
    w_f_add   = (func == F_ADD);
    w_f_sub   = (func == F_SUB);
    w_f_and   = (func == F_AND);
    w_f_or    = (func == F_OR);
    w_f_slt   = (func == F_SLT);
    w_rtype   = (OP == OP_R) &&
                (w_f_add || w_f_sub || w_f_and ||
                 w_f_or  || w_f_slt);
    w_addi    = (OP == OP_ADDI);
    w_ori     = (OP == OP_ORI);
    w_lw      = (OP == OP_LW);
    w_sw      = (OP == OP_SW);
    w_beq     = (OP == OP_BEQ);
    w_j       = (OP == OP_J);
    w_ovf_chk = w_addi ||
                (w_rtype && (w_f_add || w_f_sub));
  end

  // ALU controls shared by the execute and writeback states.
  always_comb begin
    w_ex_alusrc = 1'b0;
    w_ex_extop  = 1'b0;
    w_ex_aluctr = ALU_ADD;
    if (w_rtype) begin
      unique case (1'b1)
        w_f_sub: w_ex_aluctr = ALU_SUB;
        w_f_and: w_ex_aluctr = ALU_AND;
        w_f_or:  w_ex_aluctr = ALU_OR;
        w_f_slt: w_ex_aluctr = ALU_SLT;
        default: w_ex_aluctr = ALU_ADD;
      endcase
    end else if (w_addi) begin
      w_ex_alusrc = 1'b1;
      w_ex_extop  = 1'b1;
      w_ex_aluctr = ALU_ADD;
    end else if (w_ori) begin
      w_ex_alusrc = 1'b1;
      w_ex_extop  = 1'b0;
      w_ex_aluctr = ALU_OR;
    end
  end

  // State register with synchronous reset to fetch.
  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_IF;
    else       r_state <= w_next;
  end

  // Next-state and output decode; reset masks all strobes.
  always_comb begin
    w_next    = S_IF;
    PCWr      = 1'b0;
    IRWr      = 1'b0;
    RegWr     = 1'b0;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    ALUsrc    = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    ExtOp     = 1'b0;
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    ALUctr    = ALU_ADD;
    PCsrc     = 2'b00;
    unique case (r_state)
      S_IF: begin
        PCWr   = 1'b1;
        IRWr   = 1'b1;
        w_next = S_ID;
      end
      S_ID: begin
        if (w_j) begin
          PCWr      = 1'b1;
          PCsrc     = 2'b10;
          InstrDone = 1'b1;
          w_next    = S_IF;
        end else if (w_beq) begin
          w_next = S_BR;
        end else if (w_rtype || w_addi || w_ori) begin
          w_next = S_EX;
        end else if (w_lw || w_sw) begin
          w_next = S_MA;
        end else begin
          Illegal   = 1'b1;
          InstrDone = 1'b1;
          w_next    = S_IF;
        end
      end
      S_EX: begin
        ALUsrc = w_ex_alusrc;
        ExtOp  = w_ex_extop;
        ALUctr = w_ex_aluctr;
        w_next = S_WB;
      end
      S_WB: begin
        ALUsrc    = w_ex_alusrc;
        ExtOp     = w_ex_extop;
        ALUctr    = w_ex_aluctr;
        RegDst    = w_rtype;
        RegWr     = !(Overflow && w_ovf_chk);
        InstrDone = 1'b1;
        w_next    = S_IF;
      end
      S_MA: begin
        ALUsrc = 1'b1;
        ExtOp  = 1'b1;
        w_next = S_MEM;
      end
      S_MEM: begin
        ALUsrc = 1'b1;
        ExtOp  = 1'b1;
        MemRd  = w_lw;
        MemWr  = w_sw;
        if (!(w_lw || w_sw)) begin
          w_next = S_IF;
        end else if (!MemReady) begin
          w_next = S_MEM;
        end else if (w_lw) begin
          w_next = S_LW;
        end else begin
          InstrDone = 1'b1;
          w_next    = S_IF;
        end
      end
      S_LW: begin
        ALUsrc    = 1'b1;
        ExtOp     = 1'b1;
        RegWr     = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
        w_next    = S_IF;
      end
      S_BR: begin
        ALUctr    = ALU_SUB;
        PCWr      = Zero;
        PCsrc     = 2'b01;
        InstrDone = 1'b1;
        w_next    = S_IF;
      end
      default: w_next = S_IF;
    endcase
    if (Reset) begin
      PCWr      = 1'b0;
      IRWr      = 1'b0;
      RegWr     = 1'b0;
      MemRd     = 1'b0;
      MemWr     = 1'b0;
      InstrDone = 1'b0;
      Illegal   = 1'b0;
      w_next    = S_IF;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl.
// Driver queues hand-computed per-cycle outputs; monitor compares.
module tb_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] OP;
  logic [5:0] func;
  logic       Zero;
  logic       Overflow;
  logic       MemReady;
  logic       PCWr, IRWr, RegWr, MemRd, MemWr;
  logic       ALUsrc, RegDst, MemtoReg, ExtOp;
  logic       InstrDone, Illegal;
  logic [2:0] ALUctr;
  logic [1:0] PCsrc;
  logic [2:0] state;

  multicycle_ctrl dut (
    .CLK(CLK), .Reset(Reset), .OP(OP), .func(func),
    .Zero(Zero), .Overflow(Overflow), .MemReady(MemReady),
    .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr),
    .MemRd(MemRd), .MemWr(MemWr), .ALUsrc(ALUsrc),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ExtOp(ExtOp),
    .InstrDone(InstrDone), .Illegal(Illegal),
    .ALUctr(ALUctr), .PCsrc(PCsrc), .state(state)
  );

  always #5 CLK = ~CLK;

  // Expected vector: state, 11 flags, ALUctr, PCsrc.
  // Flag order: PCWr IRWr RegWr MemRd MemWr ALUsrc
  //             RegDst MemtoReg ExtOp InstrDone Illegal
  typedef struct {
    string       nm;
    logic [18:0] v;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   drv_done = 1'b0;

  function automatic logic [18:0] mk(
    input logic [2:0]  st,
    input logic [10:0] fl,
    input logic [2:0]  ac,
    input logic [1:0]  pc
  );
    return {st, fl, ac, pc};
  endfunction

  task automatic cyc(input string nm, input logic [18:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic setop(input logic [5:0] o, input logic [5:0] f);
    OP   = o;
    func = f;
  endtask

  localparam logic [10:0] F_IF = 11'b11000000000;
  localparam logic [10:0] F_NO = 11'b00000000000;

  // Monitor: compare DUT outputs against queued expectations.
  initial begin
    logic [18:0] act;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {state, PCWr, IRWr, RegWr, MemRd, MemWr,
               ALUsrc, RegDst, MemtoReg, ExtOp,
               InstrDone, Illegal, ALUctr, PCsrc};
        n_chk++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b want %b", e.nm, act, e.v);
        end
      end
    end
  end

  // Driver: directed instruction sequences.
  initial begin
    Reset = 1'b1; OP = 6'd0; func = 6'd0;
    Zero = 1'b0; Overflow = 1'b0; MemReady = 1'b1;
    @(posedge CLK); #1;
    cyc("reset", mk(3'd0, F_NO, 3'b000, 2'b00));
    Reset = 1'b0;

    // add, no overflow
    setop(6'b000000, 6'b100000);
    cyc("add_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("add_id", mk(3'd1, F_NO, 3'b000, 2'b00));
    cyc("add_ex", mk(3'd2, F_NO, 3'b000, 2'b00));
    cyc("add_wb", mk(3'd3, 11'b00100010010, 3'b000, 2'b00));

    // sub with overflow suppresses write
    setop(6'b000000, 6'b100010); Overflow = 1'b1;
    cyc("sub_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("sub_id", mk(3'd1, F_NO, 3'b000, 2'b00));
    cyc("sub_ex", mk(3'd2, F_NO, 3'b001, 2'b00));
    cyc("sub_wb", mk(3'd3, 11'b00000010010, 3'b001, 2'b00));

    // slt with overflow flag set still writes
    setop(6'b000000, 6'b101010);
    cyc("slt_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("slt_id", mk(3'd1, F_NO, 3'b000, 2'b00));
    cyc("slt_ex", mk(3'd2, F_NO, 3'b100, 2'b00));
    cyc("slt_wb", mk(3'd3, 11'b00100010010, 3'b100, 2'b00));

    // and / or execute codes
    setop(6'b000000, 6'b100100); Overflow = 1'b0;
    cyc("and_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("and_id", mk(3'd1, F_NO, 3'b000, 2'b00));
    cyc("and_ex", mk(3'd2, F_NO, 3'b010, 2'b00));
    cyc("and_wb", mk(3'd3, 11'b00100010010, 3'b010, 2'b00));
    setop(6'b000000, 6'b100101);
    cyc("or_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("or_id", mk(3'd1, F_NO, 3'b000, 2'b00));
    cyc("or_ex", mk(3'd2, F_NO, 3'b011, 2'b00));
    cyc("or_wb", mk(3'd3, 11'b00100010010, 3'b011, 2'b00));

    // addi with overflow
    setop(6'b001000, 6'b111111); Overflow = 1'b1;
    cyc("addi_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("addi_id", mk(3'd1, F_NO, 3'b000, 2'b00));
    cyc("addi_ex", mk(3'd2, 11'b00000100100, 3'b000, 2'b00));
    cyc("addi_wb", mk(3'd3, 11'b00000100110, 3'b000, 2'b00));

    // ori ignores overflow, zero-extends
    setop(6'b001101, 6'b000000);
    cyc("ori_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("ori_id", mk(3'd1, F_NO, 3'b000, 2'b00));
    cyc("ori_ex", mk(3'd2, 11'b00000100000, 3'b011, 2'b00));
    cyc("ori_wb", mk(3'd3, 11'b00100100010, 3'b011, 2'b00));
    Overflow = 1'b0;

    // lw with three wait cycles
    setop(6'b100011, 6'b000000); MemReady = 1'b0;
    cyc("lw_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("lw_id", mk(3'd1, F_NO, 3'b000, 2'b00));
    cyc("lw_ma", mk(3'd4, 11'b00000100100, 3'b000, 2'b00));
    for (int i = 0; i < 3; i++)
      cyc("lw_wait", mk(3'd5, 11'b00010100100, 3'b000, 2'b00));
    MemReady = 1'b1;
    cyc("lw_mem", mk(3'd5, 11'b00010100100, 3'b000, 2'b00));
    cyc("lw_wb", mk(3'd6, 11'b00100101110, 3'b000, 2'b00));

    // sw, memory ready immediately
    setop(6'b101011, 6'b000000);
    cyc("sw_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("sw_id", mk(3'd1, F_NO, 3'b000, 2'b00));
    cyc("sw_ma", mk(3'd4, 11'b00000100100, 3'b000, 2'b00));
    cyc("sw_mem", mk(3'd5, 11'b00001100110, 3'b000, 2'b00));

    // beq taken then not taken
    setop(6'b000100, 6'b000000); Zero = 1'b1;
    cyc("beqt_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("beqt_id", mk(3'd1, F_NO, 3'b000, 2'b00));
    cyc("beqt_br", mk(3'd7, 11'b10000000010, 3'b001, 2'b01));
    Zero = 1'b0;
    cyc("beqn_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("beqn_id", mk(3'd1, F_NO, 3'b000, 2'b00));
    cyc("beqn_br", mk(3'd7, 11'b00000000010, 3'b001, 2'b01));

    // jump
    setop(6'b000010, 6'b000000);
    cyc("j_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("j_id", mk(3'd1, 11'b10000000010, 3'b000, 2'b10));

    // illegal opcode and illegal R-type func
    setop(6'b111111, 6'b000000);
    cyc("ill_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("ill_id", mk(3'd1, 11'b00000000011, 3'b000, 2'b00));
    setop(6'b000000, 6'b000001);
    cyc("illf_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("illf_id", mk(3'd1, 11'b00000000011, 3'b000, 2'b00));

    // reset during sw memory wait
    setop(6'b101011, 6'b000000); MemReady = 1'b0;
    cyc("swr_if", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("swr_id", mk(3'd1, F_NO, 3'b000, 2'b00));
    cyc("swr_ma", mk(3'd4, 11'b00000100100, 3'b000, 2'b00));
    cyc("swr_wait", mk(3'd5, 11'b00001100100, 3'b000, 2'b00));
    Reset = 1'b1;
    cyc("swr_rst", mk(3'd5, 11'b00000100100, 3'b000, 2'b00));
    Reset = 1'b0;
    cyc("swr_if2", mk(3'd0, F_IF, 3'b000, 2'b00));
    cyc("swr_id2", mk(3'd1, F_NO, 3'b000, 2'b00));
    drv_done = 1'b1;
  end

  // Drain scoreboard with a bounded wait, then summarise.
  initial begin
    int budget;
    budget = 2000;
    while (!(drv_done && q.size() == 0) && budget > 0) begin
      @(posedge CLK);
      budget--;
    end
    if (budget == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got %0d pending want 0", q.size());
    end
    @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
